// File: rtl/leaf_router_gen2.sv
// leaf_router_gen2: leaf router between one GPU port and NUM_SPINES spine ports,
//   with per-input FIFOs, round-robin GPU egress arbitration and a saturating drop counter.
// Latency: 2 cycles from ingress accept to egress valid (no fall-through); 1 flit/cycle per output.
// Backpressure: in_ready = !fifo_full (registered); egress registers hold flits until out_ready.
// Ports: clk/reset (async active-high); arb_enable gates pops and drops;
//   gpu_in_* / spine_in_* ingress (data, dest {group,leaf}, valid/ready);
//   gpu_out_* / spine_out_* egress (valid/ready, spine also passes dest);
//   fifo_full/fifo_empty (bit 0 GPU, bit i+1 spine i); drop_count; busy; current_grant.
// Optional: define LEAF_ROUTER_STATS_EN to add flit_count, 16-bit wrapping handshake
//   counters per egress (slice 0 GPU, slice s+1 spine s).
module leaf_router_gen2 #(
  parameter int unsigned ROUTER_ID  = 3,
  parameter logic [3:0]  GROUP_ID   = 4'b0101,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned NUM_SPINES = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         arb_enable,
  input  logic [DWIDTH-1:0]            gpu_in_data,
  input  logic [5:0]                   gpu_in_dest,
  input  logic                         gpu_in_valid,
  output logic                         gpu_in_ready,
  output logic [DWIDTH-1:0]            gpu_out_data,
  output logic                         gpu_out_valid,
  input  logic                         gpu_out_ready,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES*6-1:0]      spine_in_dest,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES-1:0]        spine_in_ready,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES*6-1:0]      spine_out_dest,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_out_ready,
  output logic [NUM_SPINES:0]          fifo_full,
  output logic [NUM_SPINES:0]          fifo_empty,
  output logic [7:0]                   drop_count,
  output logic                         busy,
  output logic [2:0]                   current_grant
`ifdef LEAF_ROUTER_STATS_EN
  ,
  output logic [16*(NUM_SPINES+1)-1:0] flit_count
`endif
);
  localparam int unsigned NP  = NUM_SPINES + 1;
  localparam int unsigned FW  = DWIDTH + 6;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned PIW = $clog2(NP);
  localparam logic [5:0]  LOCAL_ADDR = {GROUP_ID, 2'(ROUTER_ID)};

  // Per-input FIFOs; port 0 is the GPU, port i+1 is spine i. Entries are {dest, data}.
  logic [NP-1:0]         w_in_vld, w_push, w_pop, w_full, w_empty, w_local, w_drop;
  logic [NP-1:0][FW-1:0] w_in_fl, w_head;

  assign w_in_vld = {spine_in_valid, gpu_in_valid};

  for (genvar p = 0; p < NP; p++) begin : g_fifo
    logic [FIFO_DEPTH-1:0][FW-1:0] r_mem;
    logic [AW-1:0]                 r_wptr, r_rptr;
    logic [CW-1:0]                 r_cnt;

    if (p == 0) begin : g_gpu
      assign w_in_fl[p] = {gpu_in_dest, gpu_in_data};
    end else begin : g_spine
      assign w_in_fl[p] = {spine_in_dest[(p-1)*6 +: 6], spine_in_data[(p-1)*DWIDTH +: DWIDTH]};
    end

    // Full is taken from the registered count, so a same-cycle pop never admits a push.
    assign w_full[p]  = (r_cnt == CW'(FIFO_DEPTH));
    assign w_empty[p] = (r_cnt == '0);
    assign w_push[p]  = w_in_vld[p] && !w_full[p];
    assign w_head[p]  = r_mem[r_rptr];
    assign w_local[p] = (w_head[p][FW-1 -: 6] == LOCAL_ADDR);

    always_ff @(posedge clk) begin
      if (w_push[p]) r_mem[r_wptr] <= w_in_fl[p];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[p]) r_wptr <= r_wptr + 1'b1;
        if (w_pop[p])  r_rptr <= r_rptr + 1'b1;
        r_cnt <= r_cnt + CW'(w_push[p]) - CW'(w_pop[p]);
      end
    end
  end

  assign fifo_full      = w_full;
  assign fifo_empty     = w_empty;
  assign gpu_in_ready   = !w_full[0];
  assign spine_in_ready = ~w_full[NP-1:1];

  // Egress registers and control state.
  logic                              r_gpu_vld;
  logic [DWIDTH-1:0]                 r_gpu_dat;
  logic [NUM_SPINES-1:0]             r_sp_vld;
  logic [NUM_SPINES-1:0][DWIDTH-1:0] r_sp_dat;
  logic [NUM_SPINES-1:0][5:0]        r_sp_dest;
  logic [7:0]                        r_drop;
  logic [1:0]                        r_rr, r_grant;

  logic          w_gpu_free, w_gnt_vld;
  logic [3:0]    w_sp_free, w_sp_load, w_req;
  logic [1:0]    w_gpu_tgt, w_gnt, w_rr_idx;
  logic [FW-1:0] w_gnt_fl;
  logic [8:0]    w_drop_sum;

  assign w_gpu_free = !r_gpu_vld || gpu_out_ready;
  assign w_sp_free  = 4'(~r_sp_vld | spine_out_ready);
  assign w_gpu_tgt  = w_head[0][DWIDTH +: 2] & 2'(NUM_SPINES - 1);
  assign w_gnt_fl   = w_head[PIW'(w_gnt) + PIW'(1)];
  assign w_drop_sum = {1'b0, r_drop} + 9'($countones(w_drop));

  always_comb begin
    w_pop     = '0;
    w_drop    = '0;
    w_sp_load = '0;
    w_req     = '0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_rr_idx  = '0;
    if (arb_enable) begin
      // GPU head: self-addressed flits are discarded, others go to spine dest[1:0].
      if (!w_empty[0]) begin
        if (w_local[0]) begin
          w_pop[0]  = 1'b1;
          w_drop[0] = 1'b1;
        end else if (w_sp_free[w_gpu_tgt]) begin
          w_pop[0]             = 1'b1;
          w_sp_load[w_gpu_tgt] = 1'b1;
        end
      end
      // Spine heads: local flits request the GPU egress, anything else is discarded.
      for (int i = 0; i < NUM_SPINES; i++) begin
        if (!w_empty[i+1]) begin
          if (w_local[i+1]) begin
            w_req[i] = 1'b1;
          end else begin
            w_pop[i+1]  = 1'b1;
            w_drop[i+1] = 1'b1;
          end
        end
      end
      // Scan backwards so the surviving hit is the first requester at or after r_rr.
      if (w_gpu_free) begin
        for (int k = NUM_SPINES - 1; k >= 0; k--) begin
          w_rr_idx = 2'((int'(r_rr) + k) % int'(NUM_SPINES));
          if (w_req[w_rr_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_rr_idx;
          end
        end
        if (w_gnt_vld) w_pop[PIW'(w_gnt) + PIW'(1)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gpu_vld <= 1'b0;
      r_gpu_dat <= '0;
      r_sp_vld  <= '0;
      r_sp_dat  <= '0;
      r_sp_dest <= '0;
      r_drop    <= '0;
      r_rr      <= '0;
      r_grant   <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_gpu_vld <= 1'b1;
        r_gpu_dat <= w_gnt_fl[DWIDTH-1:0];
        r_grant   <= w_gnt;
        r_rr      <= 2'((int'(w_gnt) + 1) % int'(NUM_SPINES));
      end else if (gpu_out_ready) begin
        r_gpu_vld <= 1'b0;
      end
      for (int s = 0; s < NUM_SPINES; s++) begin
        if (w_sp_load[s]) begin
          r_sp_vld[s]  <= 1'b1;
          r_sp_dat[s]  <= w_head[0][DWIDTH-1:0];
          r_sp_dest[s] <= w_head[0][FW-1 -: 6];
        end else if (spine_out_ready[s]) begin
          r_sp_vld[s] <= 1'b0;
        end
      end
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign gpu_out_valid   = r_gpu_vld;
  assign gpu_out_data    = r_gpu_dat;
  assign spine_out_valid = r_sp_vld;
  assign spine_out_data  = r_sp_dat;
  assign spine_out_dest  = r_sp_dest;
  assign drop_count      = r_drop;
  assign current_grant   = {1'b0, r_grant};
  assign busy            = !(&w_empty) || r_gpu_vld || (|r_sp_vld);

`ifdef LEAF_ROUTER_STATS_EN
  logic [NP-1:0][15:0] r_flit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flit_cnt <= '0;
    end else begin
      if (r_gpu_vld && gpu_out_ready) r_flit_cnt[0] <= r_flit_cnt[0] + 16'd1;
      for (int s = 0; s < NUM_SPINES; s++) begin
        if (r_sp_vld[s] && spine_out_ready[s]) r_flit_cnt[s+1] <= r_flit_cnt[s+1] + 16'd1;
      end
    end
  end

  assign flit_count = r_flit_cnt;
`endif

endmodule

// File: tb/tb_leaf_router_gen2.sv
module tb_leaf_router_gen2;
  localparam int         NS    = 4;
  localparam int         DW    = 16;
  localparam logic [3:0] GRP   = 4'b0101;
  localparam logic [5:0] LOCAL = 6'b010111;

  logic              clk = 1'b0;
  logic              reset;
  logic              arb_enable;
  logic [DW-1:0]     gpu_in_data;
  logic [5:0]        gpu_in_dest;
  logic              gpu_in_valid;
  logic              gpu_in_ready;
  logic [DW-1:0]     gpu_out_data;
  logic              gpu_out_valid;
  logic              gpu_out_ready;
  logic [NS*DW-1:0]  spine_in_data;
  logic [NS*6-1:0]   spine_in_dest;
  logic [NS-1:0]     spine_in_valid;
  logic [NS-1:0]     spine_in_ready;
  logic [NS*DW-1:0]  spine_out_data;
  logic [NS*6-1:0]   spine_out_dest;
  logic [NS-1:0]     spine_out_valid;
  logic [NS-1:0]     spine_out_ready;
  logic [NS:0]       fifo_full;
  logic [NS:0]       fifo_empty;
  logic [7:0]        drop_count;
  logic              busy;
  logic [2:0]        current_grant;
`ifdef LEAF_ROUTER_STATS_EN
  logic [16*(NS+1)-1:0] flit_count;
`endif

  always #5 clk = ~clk;

  leaf_router_gen2 #(
    .ROUTER_ID(3), .GROUP_ID(GRP), .DWIDTH(DW), .NUM_SPINES(NS), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .gpu_in_data(gpu_in_data), .gpu_in_dest(gpu_in_dest),
    .gpu_in_valid(gpu_in_valid), .gpu_in_ready(gpu_in_ready),
    .gpu_out_data(gpu_out_data), .gpu_out_valid(gpu_out_valid), .gpu_out_ready(gpu_out_ready),
    .spine_in_data(spine_in_data), .spine_in_dest(spine_in_dest),
    .spine_in_valid(spine_in_valid), .spine_in_ready(spine_in_ready),
    .spine_out_data(spine_out_data), .spine_out_dest(spine_out_dest),
    .spine_out_valid(spine_out_valid), .spine_out_ready(spine_out_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .drop_count(drop_count),
    .busy(busy), .current_grant(current_grant)
`ifdef LEAF_ROUTER_STATS_EN
    , .flit_count(flit_count)
`endif
  );

  // Reference model: per-destination queues of flits still owed by the router.
  logic [21:0] spq [NS][$];  // {dest, data} owed on spine egress s
  logic [15:0] gq  [NS][$];  // data owed on GPU egress, per source spine
  int exp_drops;
  int n_chk;
  int n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int sat255(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // Record the handshakes that will complete at the coming rising edge.
  task automatic observe();
    bit ok;
    int g;
    if (gpu_out_valid && gpu_out_ready) begin
      g  = int'(current_grant);
      ok = (g < NS) && (gq[g].size() > 0);
      check_eq("gpu_out_expected", 32'(ok), 32'd1);
      if (ok) check_eq("gpu_out_dat", 32'(gpu_out_data), 32'(gq[g].pop_front()));
    end
    for (int s = 0; s < NS; s++) begin
      if (spine_out_valid[s] && spine_out_ready[s]) begin
        ok = (spq[s].size() > 0);
        check_eq("spine_out_expected", 32'(ok), 32'd1);
        if (ok) check_eq("spine_out_flit",
                         32'({spine_out_dest[s*6 +: 6], spine_out_data[s*DW +: DW]}),
                         32'(spq[s].pop_front()));
      end
    end
    if (gpu_in_valid && gpu_in_ready) begin
      if (gpu_in_dest == LOCAL) exp_drops++;
      else spq[int'(gpu_in_dest[1:0]) % NS].push_back({gpu_in_dest, gpu_in_data});
    end
    for (int s = 0; s < NS; s++) begin
      if (spine_in_valid[s] && spine_in_ready[s]) begin
        if (spine_in_dest[s*6 +: 6] == LOCAL) gq[s].push_back(spine_in_data[s*DW +: DW]);
        else exp_drops++;
      end
    end
  endtask

  task automatic step();
    observe();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int s = 0; s < NS; s++) begin
      spq[s].delete();
      gq[s].delete();
    end
    exp_drops = 0;
  endtask

  task automatic reset_dut();
    gpu_in_valid    = 1'b0;
    spine_in_valid  = '0;
    gpu_out_ready   = 1'b1;
    spine_out_ready = '1;
    arb_enable      = 1'b1;
    reset           = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_model();
    reset = 1'b0;
  endtask

  function automatic logic [5:0] rand_gpu_dest();
    if ($urandom_range(0, 19) == 0) return LOCAL;
    return {(($urandom_range(0, 9) == 0) ? 4'($urandom) : GRP), 2'($urandom_range(0, 2))};
  endfunction

  function automatic logic [5:0] rand_spine_dest();
    if ($urandom_range(0, 29) == 0) return {4'($urandom), 2'($urandom_range(0, 2))};
    return LOCAL;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit acc;
    n_chk = 0; n_pass = 0; exp_drops = 0;
    reset = 1'b1; arb_enable = 1'b1;
    gpu_in_valid = 1'b0; gpu_in_data = '0; gpu_in_dest = '0; gpu_out_ready = 1'b1;
    spine_in_valid = '0; spine_in_data = '0; spine_in_dest = '0; spine_out_ready = '1;

    // Reset state, before any clock edge.
    #1;
    check_eq("rst_gpu_vld",   32'(gpu_out_valid),   32'd0);
    check_eq("rst_sp_vld",    32'(spine_out_valid), 32'd0);
    check_eq("rst_empty",     32'(fifo_empty),      32'h1F);
    check_eq("rst_full",      32'(fifo_full),       32'd0);
    check_eq("rst_drops",     32'(drop_count),      32'd0);
    check_eq("rst_busy",      32'(busy),            32'd0);
    check_eq("rst_grant",     32'(current_grant),   32'd0);
    check_eq("rst_gpu_rdy",   32'(gpu_in_ready),    32'd1);
    check_eq("rst_sp_dat",    32'(spine_out_data[31:0]), 32'd0);
    reset_dut();

    // GPU flit to spine 2, two-cycle latency.
    gpu_in_valid = 1'b1; gpu_in_data = 16'hA5A5; gpu_in_dest = 6'b010110;
    step();
    gpu_in_valid = 1'b0;
    check_eq("lat_e1_sp_vld", 32'(spine_out_valid), 32'd0);
    step();
    check_eq("lat_e2_sp_vld", 32'(spine_out_valid), 32'b0100);
    check_eq("lat_sp2_dat",   32'(spine_out_data[2*DW +: DW]), 32'hA5A5);
    check_eq("lat_sp2_dest",  32'(spine_out_dest[2*6 +: 6]),   32'b010110);
    check_eq("lat_gpu_vld",   32'(gpu_out_valid), 32'd0);
    step();

    // Round-robin across four simultaneous spine requesters.
    reset_dut();
    for (int i = 0; i < NS; i++) begin
      spine_in_dest[i*6 +: 6]  = LOCAL;
      spine_in_data[i*DW +: DW] = 16'(32'h1000 + i);
    end
    spine_in_valid = '1;
    step();
    spine_in_valid = '0;
    step();
    for (int k = 0; k < NS; k++) begin
      check_eq("rr_vld",   32'(gpu_out_valid), 32'd1);
      check_eq("rr_dat",   32'(gpu_out_data),  32'h1000 + 32'(k));
      check_eq("rr_grant", 32'(current_grant), 32'(k));
      step();
    end

    // Backpressure on GPU egress while spine 1 streams ten flits.
    reset_dut();
    gpu_out_ready = 1'b0;
    spine_in_dest[6 +: 6] = LOCAL;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      spine_in_data[DW +: DW] = 16'(32'h2000 + n);
      spine_in_valid = (n < 10) ? 4'b0010 : 4'b0000;
      acc = spine_in_valid[1] && spine_in_ready[1];
      step();
      if (acc) n++;
    end
    spine_in_valid = '0;
    check_eq("bp_accepted",  32'(n),                 32'd9);
    check_eq("bp_full",      32'(fifo_full[2]),      32'd1);
    check_eq("bp_in_rdy",    32'(spine_in_ready[1]), 32'd0);
    check_eq("bp_hold_dat",  32'(gpu_out_data),      32'h2000);
    step(); step();
    check_eq("bp_hold_vld",  32'(gpu_out_valid),     32'd1);
    check_eq("bp_hold_dat2", 32'(gpu_out_data),      32'h2000);
    gpu_out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check_eq("bp_drain_vld", 32'(gpu_out_valid), 32'd1);
      check_eq("bp_drain_dat", 32'(gpu_out_data),  32'h2000 + 32'(k));
      step();
    end

    // Spine-to-spine and self-addressed GPU flits are both dropped.
    reset_dut();
    spine_in_dest[0 +: 6] = 6'b001111; spine_in_data[0 +: DW] = 16'h3000; spine_in_valid = 4'b0001;
    gpu_in_dest = LOCAL; gpu_in_data = 16'h3001; gpu_in_valid = 1'b1;
    step();
    spine_in_valid = '0; gpu_in_valid = 1'b0;
    repeat (3) step();
    check_eq("drop_cnt2",    32'(drop_count),      32'd2);
    check_eq("drop_model",   32'(drop_count),      32'(sat255(exp_drops)));
    check_eq("drop_busy",    32'(busy),            32'd0);
    check_eq("drop_no_out",  32'({gpu_out_valid, spine_out_valid}), 32'd0);

    // arb_enable low freezes forwarding, ingress still fills.
    reset_dut();
    arb_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      gpu_in_valid = 1'b1; gpu_in_dest = 6'b010100; gpu_in_data = 16'(32'h4000 + k);
      step();
    end
    gpu_in_valid = 1'b0;
    repeat (3) step();
    check_eq("arb_off_vld",   32'(spine_out_valid), 32'd0);
    check_eq("arb_off_empty", 32'(fifo_empty[0]),  32'd0);
    arb_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("arb_on_vld", 32'(spine_out_valid[0]),   32'd1);
      check_eq("arb_on_dat", 32'(spine_out_data[0 +: DW]), 32'h4000 + 32'(k));
    end
    repeat (2) step();

    // Many drops per cycle, then saturation.
    reset_dut();
    for (int s = 0; s < NS; s++) spine_in_dest[s*6 +: 6] = 6'b000000;
    spine_in_valid = '1;
    repeat (10) step();
    spine_in_valid = '0;
    repeat (3) step();
    check_eq("multi_drop",  32'(drop_count), 32'(sat255(exp_drops)));
    check_eq("multi_drop40", 32'(drop_count), 32'd40);
    spine_in_valid = '1;
    repeat (70) step();
    spine_in_valid = '0;
    repeat (3) step();
    check_eq("drop_sat",    32'(drop_count), 32'd255);

    // Asynchronous reset with flits in flight.
    reset_dut();
    gpu_out_ready = 1'b0; spine_out_ready = '0;
    spine_in_dest[2*6 +: 6] = LOCAL;     spine_in_data[2*DW +: DW] = 16'h5000;
    spine_in_dest[3*6 +: 6] = 6'b000000; spine_in_data[3*DW +: DW] = 16'h5001;
    spine_in_valid = 4'b1100;
    gpu_in_valid = 1'b1; gpu_in_dest = 6'b010101; gpu_in_data = 16'h5002;
    step();
    spine_in_valid = '0; gpu_in_data = 16'h5003;
    step();
    gpu_in_valid = 1'b0;
    repeat (2) step();
    check_eq("pre_rst_gpu_vld", 32'(gpu_out_valid),   32'd1);
    check_eq("pre_rst_sp_vld",  32'(spine_out_valid), 32'b0010);
    check_eq("pre_rst_empty0",  32'(fifo_empty[0]),   32'd0);
    check_eq("pre_rst_drops",   32'(drop_count),      32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_gpu_vld", 32'(gpu_out_valid),   32'd0);
    check_eq("mid_rst_sp_vld",  32'(spine_out_valid), 32'd0);
    check_eq("mid_rst_empty",   32'(fifo_empty),      32'h1F);
    check_eq("mid_rst_drops",   32'(drop_count),      32'd0);
    check_eq("mid_rst_busy",    32'(busy),            32'd0);
    check_eq("mid_rst_gpu_dat", 32'(gpu_out_data),    32'd0);
    @(negedge clk);
    reset_dut();

    // Randomized traffic against the queue model.
    for (int c = 0; c < 1500; c++) begin
      gpu_in_valid = 1'($urandom_range(0, 1));
      gpu_in_data  = 16'($urandom);
      gpu_in_dest  = rand_gpu_dest();
      for (int s = 0; s < NS; s++) begin
        spine_in_dest[s*6 +: 6]   = rand_spine_dest();
        spine_in_data[s*DW +: DW] = 16'($urandom);
      end
      spine_in_valid  = 4'($urandom);
      gpu_out_ready   = 1'($urandom_range(0, 3) != 0);
      spine_out_ready = 4'($urandom) | 4'($urandom);
      arb_enable      = 1'($urandom_range(0, 15) != 0);
      step();
    end
    gpu_in_valid = 1'b0; spine_in_valid = '0;
    gpu_out_ready = 1'b1; spine_out_ready = '1; arb_enable = 1'b1;
    repeat (40) step();
    for (int s = 0; s < NS; s++) begin
      check_eq("rand_spq_left", 32'(spq[s].size()), 32'd0);
      check_eq("rand_gq_left",  32'(gq[s].size()),  32'd0);
    end
    check_eq("rand_drops", 32'(drop_count), 32'(sat255(exp_drops)));
    check_eq("rand_busy",  32'(busy),       32'd0);
    check_eq("rand_empty", 32'(fifo_empty), 32'h1F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
